rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/loader_pkg.sv | 23 ++
 rtl/rom_loader.sv | 184 ++++++++++++++++++
 tb/tb_rom_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the ROM download loader: the per-byte FSM state
// encoding and the default RAM window geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_pkg;

   // One downloaded byte walks IDLE -> WRITE -> READ -> CHECK -> IDLE.
   // DONE parks the loader after the source has dropped dl_active.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Default RAM window: 64 KiB starting at download address 0.
   localparam int          LD_ADDR_W = 16;
   localparam logic [24:0] LD_BASE   = 25'h0;

endpackage

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Takes a byte-wide download stream, writes every byte that falls inside a
// 2^ADDR_W window starting at BASE into a dual-port RAM, reads it back to
// verify it, and keeps a byte count and a 16-bit additive checksum.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   dl_active       download session in progress (level)
//   dl_valid        one-cycle strobe qualifying dl_addr / dl_data
//   dl_addr[24:0]   byte address of the download stream
//   dl_data[7:0]    download byte
//   dl_wait         source must hold off the next dl_valid
//   ram_we          RAM write strobe
//   ram_waddr       RAM write / readback address
//   ram_wdata       RAM write data
//   ram_doutb       RAM readback, registered, one cycle after ram_waddr
//   done            session finished, every accepted byte written and verified
//   err_verify      sticky readback mismatch
//   err_overrun     sticky dl_valid seen while dl_wait was high
//   checksum        modulo-2^16 sum of accepted bytes
//   count           accepted bytes, saturating at 2^ADDR_W
// -----------------------------------------------------------------------------
module rom_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W = LD_ADDR_W,
   parameter logic [24:0] BASE   = LD_BASE
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dl_active,
   input  logic              dl_valid,
   input  logic [24:0]       dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_wait,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_doutb,
   output logic              done,
   output logic              err_verify,
   output logic              err_overrun,
   output logic [15:0]       checksum,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_t              r_state;
   logic                r_dl_wait;
   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [7:0]          r_wdata;
   logic                r_done;
   logic                r_err_verify;
   logic                r_err_overrun;
   logic [15:0]         r_checksum;
   logic [ADDR_W:0]     r_count;
   logic                r_active_d;   // dl_active one cycle ago, for edge detect
   logic                r_seen;       // dl_active has been high since reset
   logic                r_clr_pend;   // session restart requested mid-byte

   logic [25:0]         w_off;
   logic                w_in_win;
   logic                w_rise;
   logic                w_clear;

   // One extra bit on the subtraction turns "below BASE" into a set MSB, so a
   // single all-zero test above ADDR_W covers both ends of the window.
   assign w_off    = {1'b0, dl_addr} - {1'b0, BASE};
   assign w_in_win = ((w_off >> ADDR_W) == 26'd0);
   assign w_rise   = dl_active & ~r_active_d;

   // A new session wipes the statistics once the loader is between bytes; a
   // restart that lands mid-byte is honoured when that byte completes, and the
   // byte is then attributed to the old session (not counted).
   assign w_clear  = (w_rise & ((r_state == ST_IDLE) | (r_state == ST_DONE))) |
                     ((r_state == ST_CHECK) & (r_clr_pend | w_rise));

   // Byte FSM, datapath and statistics registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_dl_wait     <= 1'b0;
         r_we          <= 1'b0;
         r_waddr       <= {ADDR_W{1'b0}};
         r_wdata       <= 8'h00;
         r_done        <= 1'b0;
         r_err_verify  <= 1'b0;
         r_err_overrun <= 1'b0;
         r_checksum    <= 16'h0000;
         r_count       <= {(ADDR_W+1){1'b0}};
         r_active_d    <= 1'b0;
         r_seen        <= 1'b0;
         r_clr_pend    <= 1'b0;
      end else begin
         r_active_d <= dl_active;
         if (dl_active) begin
            r_seen <= 1'b1;
         end
         r_we <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (dl_valid && w_in_win) begin
                  r_waddr   <= w_off[ADDR_W-1:0];
                  r_wdata   <= dl_data;
                  r_we      <= 1'b1;
                  r_dl_wait <= 1'b1;
                  r_state   <= ST_WRITE;
               end else if (!dl_active && r_seen) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (w_rise) begin
                  r_clr_pend <= 1'b1;
               end
               r_state <= ST_READ;
            end
            ST_READ: begin
               if (w_rise) begin
                  r_clr_pend <= 1'b1;
               end
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               r_dl_wait  <= 1'b0;
               r_clr_pend <= 1'b0;
               r_state    <= ST_IDLE;
               if (!w_clear) begin
                  if (ram_doutb != r_wdata) begin
                     r_err_verify <= 1'b1;
                  end
                  r_checksum <= r_checksum + {8'h00, r_wdata};
                  if (r_count != CNT_MAX) begin
                     r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
                  end
               end
            end
            ST_DONE: begin
               if (w_rise) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_dl_wait <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase

         if (w_clear) begin
            r_done        <= 1'b0;
            r_err_verify  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_checksum    <= 16'h0000;
            r_count       <= {(ADDR_W+1){1'b0}};
         end

         // An in-window strobe while busy is dropped but flagged; out-of-window
         // traffic never touches the loader.
         if (r_dl_wait && dl_valid && w_in_win) begin
            r_err_overrun <= 1'b1;
         end
      end
   end

   assign dl_wait     = r_dl_wait;
   assign ram_we      = r_we;
   assign ram_waddr   = r_waddr;
   assign ram_wdata   = r_wdata;
   assign done        = r_done;
   assign err_verify  = r_err_verify;
   assign err_overrun = r_err_overrun;
   assign checksum    = r_checksum;
   assign count       = r_count;

endmodule

// File: tb/tb_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_loader
// Two loaders share one download stream: A (64 KiB window at 0) and B
// (16-byte window at 0x10000, small enough to reach count saturation).
// A transaction-level model predicts every output each cycle; literal
// expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_rom_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, dl_active, dl_valid, corrupt_a;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;

   logic        a_wait, a_we, a_done, a_ev, a_eo;
   logic [15:0] a_waddr, a_cs;
   logic [7:0]  a_wdata, a_doutb, a_q;
   logic [16:0] a_cnt;

   logic        b_wait, b_we, b_done, b_ev, b_eo;
   logic [3:0]  b_waddr;
   logic [15:0] b_cs;
   logic [7:0]  b_wdata, b_doutb, b_q;
   logic [4:0]  b_cnt;

   rom_loader #(.ADDR_W(16), .BASE(25'h0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .dl_active(dl_active), .dl_valid(dl_valid),
      .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(a_wait), .ram_we(a_we),
      .ram_waddr(a_waddr), .ram_wdata(a_wdata), .ram_doutb(a_doutb),
      .done(a_done), .err_verify(a_ev), .err_overrun(a_eo),
      .checksum(a_cs), .count(a_cnt));

   rom_loader #(.ADDR_W(4), .BASE(25'h10000)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .dl_active(dl_active), .dl_valid(dl_valid),
      .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(b_wait), .ram_we(b_we),
      .ram_waddr(b_waddr), .ram_wdata(b_wdata), .ram_doutb(b_doutb),
      .done(b_done), .err_verify(b_ev), .err_overrun(b_eo),
      .checksum(b_cs), .count(b_cnt));

   // Dual-port RAM write ports with registered readback.
   logic [7:0] ram_a [0:65535];
   logic [7:0] ram_b [0:15];
   always @(posedge clk) begin
      if (a_we) ram_a[a_waddr] <= a_wdata;
      a_q <= ram_a[a_waddr];
      if (b_we) ram_b[b_waddr] <= b_wdata;
      b_q <= ram_b[b_waddr];
   end
   assign a_doutb = corrupt_a ? 8'h00 : a_q;
   assign b_doutb = b_q;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // busy counts the cycles a byte still occupies the loader (3 = writing).
   int m_busy[2], m_done[2], m_ev[2], m_eo[2], m_cnt[2], m_cs[2];
   int m_waddr[2], m_wdata[2], m_pend[2], m_seen[2], m_prev[2];
   int base_of[2] = '{0, 'h10000};
   int win_of[2]  = '{65536, 16};
   bit m_live = 1'b0;
   bit wait_meas = 1'b0;
   int wait_hi = 0;

   task automatic m_clear(input int i);
      m_cnt[i] = 0; m_cs[i] = 0; m_ev[i] = 0; m_eo[i] = 0; m_done[i] = 0;
   endtask

   task automatic m_step(input int i);
      int  off;
      bit  inwin, rise;
      if (!rst_n) begin
         m_clear(i);
         m_busy[i] = 0; m_waddr[i] = 0; m_wdata[i] = 0;
         m_pend[i] = 0; m_seen[i] = 0; m_prev[i] = 0;
      end else begin
         off   = int'(dl_addr) - base_of[i];
         inwin = (off >= 0) && (off < win_of[i]);
         rise  = dl_active && !m_prev[i];
         if (m_busy[i] > 0) begin
            if (rise) m_pend[i] = 1;
            if (m_busy[i] == 1) begin
               if (m_pend[i] != 0) begin
                  m_clear(i);
                  m_pend[i] = 0;
               end else begin
                  if (i == 0 && corrupt_a && m_wdata[i] != 0) m_ev[i] = 1;
                  m_cs[i] = (m_cs[i] + m_wdata[i]) % 65536;
                  if (m_cnt[i] < win_of[i]) m_cnt[i]++;
               end
            end
            m_busy[i]--;
            if (dl_valid && inwin) m_eo[i] = 1;
         end else if (m_done[i] != 0) begin
            if (rise) m_clear(i);
         end else begin
            if (rise) m_clear(i);
            if (dl_valid && inwin) begin
               m_waddr[i] = off;
               m_wdata[i] = int'(dl_data);
               m_busy[i]  = 3;
            end else if (!dl_active && m_seen[i] != 0) begin
               m_done[i] = 1;
            end
         end
         if (dl_active) m_seen[i] = 1;
         m_prev[i] = dl_active ? 1 : 0;
      end
   endtask

   task automatic cmp(input int i, input int wt, input int we, input int wa,
                      input int wd, input int dn, input int ev, input int eo,
                      input int cnt, input int cs);
      chk($sformatf("dl_wait[%0d]", i), wt, (m_busy[i] > 0) ? 1 : 0);
      chk($sformatf("ram_we[%0d]", i), we, (m_busy[i] == 3) ? 1 : 0);
      chk($sformatf("ram_waddr[%0d]", i), wa, m_waddr[i]);
      chk($sformatf("ram_wdata[%0d]", i), wd, m_wdata[i]);
      chk($sformatf("done[%0d]", i), dn, m_done[i]);
      chk($sformatf("err_verify[%0d]", i), ev, m_ev[i]);
      chk($sformatf("err_overrun[%0d]", i), eo, m_eo[i]);
      chk($sformatf("count[%0d]", i), cnt, m_cnt[i]);
      chk($sformatf("checksum[%0d]", i), cs, m_cs[i]);
   endtask

   // Compare on the falling edge, then advance the model with the inputs the
   // next rising edge will sample.
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         cmp(0, int'(a_wait), int'(a_we), int'(a_waddr), int'(a_wdata), int'(a_done),
             int'(a_ev), int'(a_eo), int'(a_cnt), int'(a_cs));
         cmp(1, int'(b_wait), int'(b_we), int'(b_waddr), int'(b_wdata), int'(b_done),
             int'(b_ev), int'(b_eo), int'(b_cnt), int'(b_cs));
      end
      if (wait_meas && a_wait) wait_hi++;
      m_step(0);
      m_step(1);
      if (!rst_n) m_live = 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // One strobe, then three busy cycles: the next call lands on IDLE.
   task automatic send(input logic [24:0] addr, input logic [7:0] data);
      dl_valid = 1'b1; dl_addr = addr; dl_data = data;
      tick();
      dl_valid = 1'b0;
      idle(3);
   endtask

   initial begin
      for (int k = 0; k < 65536; k++) ram_a[k] = 8'h00;
      for (int k = 0; k < 16; k++) ram_b[k] = 8'h00;
      rst_n = 1'b0; dl_active = 1'b0; dl_valid = 1'b0;
      dl_addr = 25'h0; dl_data = 8'h00; corrupt_a = 1'b0;
      idle(3);
      chk("rst_count", int'(a_cnt), 0);
      chk("rst_wait", int'(a_wait), 0);
      chk("rst_done", int'(a_done), 0);
      rst_n = 1'b1;
      tick();

      // Three bytes into window A, then end of session.
      dl_active = 1'b1; tick();
      send(25'h0, 8'h11); send(25'h1, 8'h22); send(25'h2, 8'h33);
      dl_active = 1'b0; idle(3);
      chk("s1_count", int'(a_cnt), 3);
      chk("s1_checksum", int'(a_cs), 'h0066);
      chk("s1_done", int'(a_done), 1);
      chk("s1_errs", int'(a_ev) + int'(a_eo), 0);
      chk("s1_ram0", int'(ram_a[0]), 'h11);
      chk("s1_ram1", int'(ram_a[1]), 'h22);
      chk("s1_ram2", int'(ram_a[2]), 'h33);

      // Window edges of B: 0x0FFFF is just below, 0x10000 is its first byte.
      dl_active = 1'b1; tick();
      dl_valid = 1'b1; dl_addr = 25'h0FFFF; dl_data = 8'hAA;
      tick();
      chk("b_wait_below_window", int'(b_wait), 0);
      dl_valid = 1'b0; idle(3);
      send(25'h10000, 8'hBB);
      dl_active = 1'b0; idle(3);
      chk("b_count", int'(b_cnt), 1);
      chk("b_ram0", int'(ram_b[0]), 'hBB);
      chk("b_checksum", int'(b_cs), 'h00BB);
      chk("a_top_byte", int'(ram_a[16'hFFFF]), 'hAA);

      // Back-to-back strobes: the second one is an overrun.
      dl_active = 1'b1; tick();
      dl_valid = 1'b1; dl_addr = 25'h5; dl_data = 8'h77;
      tick();
      dl_addr = 25'h6; dl_data = 8'h88;
      tick();
      dl_valid = 1'b0; idle(3);
      chk("ovr_flag", int'(a_eo), 1);
      chk("ovr_count", int'(a_cnt), 1);
      chk("ovr_ram5", int'(ram_a[5]), 'h77);
      chk("ovr_ram6", int'(ram_a[6]), 'h00);
      chk("ovr_b_flag", int'(b_eo), 0);
      dl_active = 1'b0; idle(2);

      // Corrupted readback; error is sticky until the next session starts.
      dl_active = 1'b1; tick();
      chk("ovr_cleared", int'(a_eo), 0);
      corrupt_a = 1'b1; send(25'h7, 8'h5A); corrupt_a = 1'b0;
      chk("ver_flag", int'(a_ev), 1);
      send(25'h8, 8'h3C);
      chk("ver_sticky", int'(a_ev), 1);
      dl_active = 1'b0; idle(3);
      chk("ver_done", int'(a_done), 1);
      dl_active = 1'b1; tick();
      chk("ver_cleared", int'(a_ev), 0);
      chk("restart_count", int'(a_cnt), 0);

      // Reset while the second byte is in READ.
      send(25'h9, 8'h42);
      chk("pre_rst_count", int'(a_cnt), 1);
      dl_valid = 1'b1; dl_addr = 25'hA; dl_data = 8'h99;
      tick();
      dl_valid = 1'b0;
      tick();
      chk("read_wait", int'(a_wait), 1);
      rst_n = 1'b0;
      tick();
      chk("rst_mid_we", int'(a_we), 0);
      chk("rst_mid_count", int'(a_cnt), 0);
      chk("rst_mid_checksum", int'(a_cs), 0);
      rst_n = 1'b1;
      tick();

      // 256 x 0xFF at full rate.
      wait_meas = 1'b1;
      for (int k = 0; k < 256; k++) send(25'(k), 8'hFF);
      wait_meas = 1'b0;
      chk("burst_wait_cycles", wait_hi, 768);
      chk("burst_count", int'(a_cnt), 256);
      chk("burst_checksum", int'(a_cs), 'hFF00);

      // Overfill B (16 bytes) with duplicates: count saturates, sum keeps going.
      for (int k = 0; k < 20; k++) send(25'h10000 + 25'(k % 16), 8'(k + 1));
      chk("sat_count", int'(b_cnt), 16);
      chk("sat_checksum", int'(b_cs), 210);
      chk("dup_ram0", int'(ram_b[0]), 17);
      chk("dup_ram3", int'(ram_b[3]), 20);
      chk("dup_ram4", int'(ram_b[4]), 5);
      dl_active = 1'b0; idle(3);
      chk("sat_done", int'(b_done), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
